// File: rtl/serial_transmitter_pkg.sv
// Shared state encoding and frame constants for serial_transmitter.
// SERIAL_TX_PARITY_EN adds the PARITY state and the even-parity helper.
package serial_transmitter_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;
`endif

endpackage

// File: rtl/serial_transmitter_fifo.sv
// Transmit buffer for serial_transmitter: wrap-around pointers with an extra
// lap bit so that full and empty can be told apart.
module serial_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/serial_transmitter.sv
// Buffered 8-bit serial transmitter (8N1, or 8E1 when SERIAL_TX_PARITY_EN is
// defined) with a registered line output and an inline bit-clock counter.
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] IN_DATA,
    input  logic       IN_WRITE,
    output logic       OUT_SERIAL_TX,
    output logic       OUT_STATUS_READY,
    output logic       OUT_STATUS_BUSY
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = $clog2(DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic                   fifo_full, fifo_empty, fifo_pop, load;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   last;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (IN_WRITE),
        .pop_i   (fifo_pop),
        .data_i  (IN_DATA),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign last = (cnt_q == CW'(DIV - 1));

    // tx_d is the level for the state being entered, so the line is a clean flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        load     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != ST_IDLE) cnt_d = last ? '0 : cnt_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = LINE_IDLE;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (last) begin
                    if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = LINE_IDLE;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (last) begin
                    state_d = ST_STOP;
                    tx_d    = LINE_IDLE;
                end
            end
`endif
            ST_STOP: begin
                if (last) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = LINE_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase

        if (load) begin
            state_d = ST_START;
            shift_d = fifo_head;
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = ~LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = even_parity(fifo_head);
`endif
        end
    end

    assign fifo_pop = load;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign OUT_SERIAL_TX    = tx_q;
    assign OUT_STATUS_READY = !fifo_full;
    assign OUT_STATUS_BUSY  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: frame-level reference model compared every
// cycle, plus directed frames with hand-computed line levels.
module tb_serial_transmitter;

    localparam int unsigned CLK_HZ = 4000;
    localparam int unsigned BAUD   = 1000;
    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int          DEPTH  = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int unsigned PAR_BITS  = 1;
    localparam logic [7:0]  LIT_BYTE  = 8'hA3;
    localparam int unsigned LIT_NBITS = 11;
    logic lit_bits [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    localparam int unsigned PAR_BITS  = 0;
    localparam logic [7:0]  LIT_BYTE  = 8'h55;
    localparam int unsigned LIT_NBITS = 10;
    logic lit_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    localparam int unsigned FL = (10 + PAR_BITS) * DIV;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN_DATA;
    logic       IN_WRITE;
    logic       OUT_SERIAL_TX, OUT_STATUS_READY, OUT_STATUS_BUSY;

    int checks = 0;
    int errors = 0;

    serial_transmitter #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .IN_DATA          (IN_DATA),
        .IN_WRITE         (IN_WRITE),
        .OUT_SERIAL_TX    (OUT_SERIAL_TX),
        .OUT_STATUS_READY (OUT_STATUS_READY),
        .OUT_STATUS_BUSY  (OUT_STATUS_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    // Reference: queue of pending bytes plus a clock count into the frame on the line.
    logic [7:0] mq [$];
    logic [7:0] mcur;
    bit         mact = 1'b0;
    int unsigned mclk = 0;
    logic exp_tx, exp_rdy, exp_busy;

    function automatic logic frame_bit(input logic [7:0] d, input int unsigned i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (PAR_BITS == 1 && i == 9) return ^d;
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        logic       w, r;
        logic [7:0] d;
        bit         acc;
        w = IN_WRITE;
        r = RESET;
        d = IN_DATA;
        if (r) begin
            mq.delete();
            mact = 1'b0;
            mclk = 0;
        end else begin
            acc = w && (mq.size() < DEPTH);
            if (mact) begin
                mclk++;
                if (mclk == FL) mact = 1'b0;
            end
            if (!mact && mq.size() > 0) begin
                mcur = mq.pop_front();
                mact = 1'b1;
                mclk = 0;
            end
            if (acc) mq.push_back(d);
        end
        exp_tx   = mact ? frame_bit(mcur, mclk / DIV) : 1'b1;
        exp_rdy  = (mq.size() < DEPTH);
        exp_busy = mact || (mq.size() > 0);
        #1;
        check("model_tx", OUT_SERIAL_TX, exp_tx);
        check("model_ready", OUT_STATUS_READY, exp_rdy);
        check("model_busy", OUT_STATUS_BUSY, exp_busy);
    end

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (!OUT_STATUS_BUSY) break;
        end
        check("idle_wait_timeout", OUT_STATUS_BUSY, 0);
    endtask

    task automatic count_busy(input string name, input int want);
        int n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!OUT_STATUS_BUSY) break;
            n++;
            @(negedge CLK);
        end
        check(name, n, want);
    endtask

    initial begin
        bit heavy = 1'b0;
        RESET    = 1'b1;
        IN_WRITE = 1'b0;
        IN_DATA  = '0;
        repeat (3) @(negedge CLK);
        check("reset_tx", OUT_SERIAL_TX, 1);
        check("reset_ready", OUT_STATUS_READY, 1);
        check("reset_busy", OUT_STATUS_BUSY, 0);
        RESET = 1'b0;

        // Single frame with hand-computed levels; IN_DATA churns after acceptance.
        wait_idle();
        @(negedge CLK);
        IN_WRITE = 1'b1;
        IN_DATA  = LIT_BYTE;
        @(negedge CLK);
        IN_WRITE = 1'b0;
        IN_DATA  = 8'($urandom);
        for (int c = 0; c < int'(LIT_NBITS * DIV); c++) begin
            @(posedge CLK);
            #1;
            check("lit_frame_bit", OUT_SERIAL_TX, lit_bits[c / DIV]);
            IN_DATA = 8'($urandom);
        end
        @(posedge CLK);
        #1;
        check("lit_end_busy", OUT_STATUS_BUSY, 0);
        check("lit_end_tx", OUT_SERIAL_TX, 1);

        // Six writes on consecutive edges: sixth is dropped, five frames back-to-back.
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i == 5) check("ready_at_6th_write", OUT_STATUS_READY, 0);
            IN_WRITE = 1'b1;
            IN_DATA  = 8'(i + 1);
        end
        @(negedge CLK);
        IN_WRITE = 1'b0;
        count_busy("burst_busy_len", 5 * FL - 4);

        // Push coinciding with a pop while one short of full.
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            IN_WRITE = 1'b1;
            IN_DATA  = 8'(8'hA1 + 8'(i * 17));
        end
        @(negedge CLK);
        IN_WRITE = 1'b0;
        repeat (FL - 3) @(negedge CLK);
        check("ready_before_pushpop", OUT_STATUS_READY, 1);
        IN_WRITE = 1'b1;
        IN_DATA  = 8'hE5;
        @(negedge CLK);
        IN_WRITE = 1'b0;
        check("ready_after_pushpop", OUT_STATUS_READY, 1);
        count_busy("pushpop_busy_len", 4 * FL);

        // Reset mid-frame of 0x00 with another byte queued.
        wait_idle();
        @(negedge CLK);
        IN_WRITE = 1'b1;
        IN_DATA  = 8'h00;
        @(negedge CLK);
        IN_DATA  = 8'h7E;
        @(negedge CLK);
        IN_WRITE = 1'b0;
        repeat (14) @(negedge CLK);
        check("tx_low_before_reset", OUT_SERIAL_TX, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_tx", OUT_SERIAL_TX, 1);
        check("abort_ready", OUT_STATUS_READY, 1);
        check("abort_busy", OUT_STATUS_BUSY, 0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (60) @(negedge CLK);
        check("abort_still_idle", OUT_STATUS_BUSY, 0);

        // Randomized traffic with occasional resets and bursty writes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            if (cyc % 250 == 0) heavy = ($urandom_range(0, 1) == 1);
            RESET    = ($urandom_range(0, 699) == 0);
            IN_WRITE = heavy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            IN_DATA  = 8'($urandom);
        end
        @(negedge CLK);
        RESET    = 1'b0;
        IN_WRITE = 1'b0;
        wait_idle();
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, which is the CLK frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, which is the serial bit rate; DIV = CLK_HZ/BAUD (integer, >= 2) is the number of clocks per bit.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, which is the number of transmit buffer entries (power of two, >= 2).
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: a synchronous, active-high reset.
REQ-006 The block SHALL have port IN_DATA, input, 8 bits: the byte to transmit.
REQ-007 The block SHALL have port IN_WRITE, input, 1 bit: a write strobe that pushes IN_DATA into the buffer.
REQ-008 The block SHALL have port OUT_SERIAL_TX, output, 1 bit: the serial line, idle high.
REQ-009 The block SHALL have port OUT_STATUS_READY, output, 1 bit: high when the buffer is not full.
REQ-010 The block SHALL have port OUT_STATUS_BUSY, output, 1 bit: high while a frame is on the line or the buffer is non-empty.

Function
REQ-011 A write SHALL be accepted iff IN_WRITE=1 and OUT_STATUS_READY=1 at the same edge; a write while full SHALL be dropped silently, with no state change.
REQ-012 The buffer SHALL be FIFO-ordered with wrap-around read and write pointers; a simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY (only when the parity feature is compiled in), and STOP.
REQ-014 In IDLE with the buffer non-empty, the FSM SHALL pop the head entry into the shift register, clear the bit-clock counter, and enter START on the same edge.
REQ-015 OUT_SERIAL_TX SHALL be registered, and SHALL be: 1 in IDLE; 0 in START; shift[0] in DATA (LSB first); the parity bit in PARITY; 1 in STOP.
REQ-016 Each state other than IDLE SHALL last exactly DIV clocks, timed by a counter running 0..DIV-1; a bit index 0..7 SHALL count the DATA bits.
REQ-017 The transitions SHALL be START→DATA, then DATA (after bit 7)→PARITY or STOP, then PARITY→STOP, then STOP→START (if the buffer is non-empty, popping the next entry with no idle gap) or STOP→IDLE.
REQ-018 Latency: a write accepted at edge N into an empty buffer while in IDLE SHALL make OUT_SERIAL_TX go 0 after edge N+1.
REQ-019 The frame length SHALL be 10*DIV clocks, or 11*DIV clocks with parity.
REQ-020 IN_DATA changes after acceptance SHALL NOT affect the frame.
REQ-021 OUT_STATUS_BUSY SHALL be 0 only when the FSM is in IDLE and the buffer is empty.

Reset
REQ-022 When RESET=1 at an edge, the block SHALL set the FSM to IDLE, empty the FIFO, zero the counters, and drive OUT_SERIAL_TX=1, OUT_STATUS_READY=1, and OUT_STATUS_BUSY=0 after that edge.
REQ-023 A reset asserted mid-frame SHALL abort the frame immediately, with the line high after the edge; buffered bytes SHALL be discarded.
REQ-024 RESET SHALL take priority over IN_WRITE.

Configuration
REQ-025 When macro SERIAL_TX_PARITY_EN is defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit.
REQ-026 When SERIAL_TX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and the frame SHALL be 8N1.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the frame-width constants (DATA_BITS=8), and the idle line level.
REQ-028 The block SHALL use one sub-module, serial_tx_fifo (parameterised depth/width, push/pop/full/empty), and SHALL keep the bit-clock counter inline.

Verification (CLK_HZ=4000, BAUD=1000, so DIV=4)
REQ-029 The bench SHALL cover: write 0x55 while idle → after 1 clock, TX = 0,1,0,1,0,1,0,1,0,1 with each bit held 4 clocks, 40 clocks total, then BUSY=0.
REQ-030 The bench SHALL cover, with SERIAL_TX_PARITY_EN: write 0xA3 → data bits 1,1,0,0,0,1,0,1, parity 0, stop 1, 44 clocks total.
REQ-031 The bench SHALL cover 6 writes on consecutive edges (0x01..0x06) while idle: 0x01 pops at once, 0x02..0x05 fill the buffer, READY=0 at the 6th write so 0x06 is dropped; five frames go out back-to-back with no idle gap.
REQ-032 The bench SHALL cover a write at the same edge as a pop with the buffer full minus one: both succeed and occupancy is unchanged.
REQ-033 The bench SHALL cover RESET asserted at clock 15 of a 0x00 frame: TX=1 on the next cycle, READY=1, BUSY=0, and no further frames.
REQ-034 The bench SHALL cover IN_DATA toggled every cycle after acceptance: the transmitted byte equals the value captured at acceptance.
